sobel_3x3_core: RTL and testbench
=================================

# sobel_3x3_core

Parametrised 3x3 Sobel edge operator for the streaming image pipeline. It sits downstream of the two-line-buffer block, which delivers the top, middle and bottom rows of a column each valid cycle. The block keeps its own column and row position counters and forces border pixels to zero. It computes signed Gx/Gy at full precision, forms |Gx|+|Gy| with saturation, and outputs either the magnitude or a thresholded binary map, with frame-start tracking and a fixed 2-cycle latency.

## Interface
- DATA_W, 8: pixel width in bits; output uses the same width
- IMG_W, 640: pixels per line (≥3)
- IMG_H, 480: lines per frame (≥3)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  column triplet din1/din2/din3 valid this cycle
- sof_in  in  1  first pixel of frame; qualified by valid_in
- din1  in  DATA_W  top row pixel
- din2  in  DATA_W  centre row pixel
- din3  in  DATA_W  bottom row pixel
- mode  in  1  0 = magnitude output, 1 = binary output
- thresh  in  DATA_W+3  edge threshold on unsaturated magnitude
- valid_out  out  1  dout/edge_out valid
- sof_out  out  1  sof_in delayed with its pixel
- dout  out  DATA_W  magnitude or binary pixel
- edge_out  out  1  magnitude > threshold

## Operation
- Window: 3 columns x 3 rows of shift registers (w[r][0] newest, w[r][2] oldest). Shifts only on valid_in; holds otherwise.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the index of the current input pixel.
  - valid_in & sof_in: the pixel is index (0,0); the counters then load col=1, row=0.
  - Otherwise, on valid_in: col increments; at IMG_W-1 it wraps to 0 and row increments; row wraps from IMG_H-1 to 0.
- Config capture: mode_r/thresh_r load from mode/thresh on valid_in & sof_in only. Reset values are 0 and all-ones. A change mid-frame has no effect until the next sof.
- Stage 1 registers these values on the cycle after the window shift:
  - Gx = (w0[0]+2·w1[0]+w2[0]) − (w0[2]+2·w1[2]+w2[2])
  - Gy = (w2[0]+2·w2[1]+w2[2]) − (w0[0]+2·w0[1]+w0[2])
  - Both are signed, DATA_W+3 bits, with no truncation.
- Stage 2:
  - mag = |Gx|+|Gy|, unsigned DATA_W+3 bits. Maximum 8·(2^DATA_W−1) fits.
  - sat = min(mag, 2^DATA_W−1)
  - edge_out = mag > thresh_r
  - dout: when mode_r=0, dout=sat. When mode_r=1, dout is all-ones if edge_out is set, else 0.
- Border: a pixel is a border pixel if col<2, row==0 or row==IMG_H−1, evaluated at input. For a border pixel, dout=0 and edge_out=0, but valid_out is still asserted.
- Exactly one output per valid_in. The pipeline never stalls; gaps in valid_in propagate as gaps in valid_out.

## Timing
- Latency: a pixel on valid_in in cycle n gives valid_out in cycle n+2.
  - The border flag, sof and valid each travel in a 2-deep register chain alongside the data.
- Stage registers update every cycle. Valid bits gate only the output interpretation; the window itself shifts only on valid_in.
- Reset (asynchronous, any time) forces:
  - valid_out=0, sof_out=0, dout=0, edge_out=0
  - counters, window, Gx/Gy and valid chain to 0
  - config registers to their reset values
  - In-flight pixels are discarded. The first valid_out after reset release appears no earlier than 2 cycles after the first valid_in.
- sof_in mid-line: counters resync immediately; the prior partial line is not padded.
- When sof_in and a wrap coincide, sof wins.
- Outputs stay stable while valid_out=0, holding the last values.

## Test plan
Benches use DATA_W=8, IMG_W=8, IMG_H=4.
- Reset then idle: all outputs 0. Assert rst_n=0 mid-frame: valid_out drops within the same cycle, and the next frame restarts at (0,0).
- Flat frame, all pixels 100, continuous valid_in: 32 valid_out pulses, each 2 cycles after its input. All dout=0. sof_out is on the first output only.
- Vertical step, columns 0–3 = 0 and columns 4–7 = 255, thresh=500, mode=0:
  - Rows 1–2 at output cols 4 and 5: Gx=1020, Gy=0, dout=255, edge_out=1.
  - Col 6: dout=0.
  - Rows 0 and 3, and cols 0–1: 0.
- Reversed step and ramp:
  - 255→0 step: Gx=−1020 → dout=255.
  - Ramp with pixel = 10·col: interior dout=80. With thresh=100, edge_out=0; with thresh=79, edge_out=1.
- Mode and config capture: drive mode=1, thresh=500 with sof, then drive mode=0 mid-frame.
  - Step edge pixels still output 255 and non-edges 0 for the whole frame.
  - mode=0 takes effect only after the next sof.
- Gapped valid_in (1 cycle on, 2 off) plus a mid-line sof_in:
  - Outputs match the continuous case in value and order.
  - col restarts at 0 on the sof, and the first two pixels after it are border pixels (0).

Source files
------------

// File: rtl/sobel_3x3_core.sv
// 3x3 Sobel edge operator on a streaming column-triplet input.
// Produces a saturated |Gx|+|Gy| magnitude or a thresholded binary map.
// Border pixels are forced to zero. Latency is fixed at two cycles.
module sobel_3x3_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              mode,
  input  logic [DATA_W+2:0] thresh,
  output logic              valid_out,
  output logic              sof_out,
  output logic [DATA_W-1:0] dout,
  output logic              edge_out
);

  localparam int unsigned GW    = DATA_W + 3;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [GW-1:0]     SAT_MAX  = GW'({DATA_W{1'b1}});
  localparam logic [DATA_W-1:0] PIX_ONES = {DATA_W{1'b1}};

  logic [DATA_W-1:0] win     [3][3];
  logic [DATA_W-1:0] win_nxt [3][3];
  logic [DATA_W-1:0] din_col [3];
  logic [GW-1:0]     px      [3][3];

  logic [COL_W-1:0]  col, pix_col;
  logic [ROW_W-1:0]  row, pix_row;
  logic              border_c;

  logic              mode_r;
  logic [GW-1:0]     thresh_r;

  logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GW-1:0] gx_c, gy_c, gx_r, gy_r;
  logic                 v1, sof1, bord1;

  logic [GW-1:0]     gx_abs, gy_abs, mag_c;
  logic [DATA_W-1:0] sat_c, dout_c;
  logic              edge_c;

  // Window as it stands after this cycle's shift (unchanged when idle)
  always_comb begin
    din_col[0] = din1;
    din_col[1] = din2;
    din_col[2] = din3;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_nxt[r][c] = win[r][c];
      end
      if (valid_in) begin
        win_nxt[r][0] = din_col[r];
        win_nxt[r][1] = win[r][0];
        win_nxt[r][2] = win[r][1];
      end
    end
  end

  // Window shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= win_nxt[r][c];
    end
  end

  // Column/row position of the pixel arriving now; sof overrides any wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (sof_in) begin
        col <= COL_W'(1);
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Border classification of the incoming pixel
  always_comb begin
    pix_col  = sof_in ? '0 : col;
    pix_row  = sof_in ? '0 : row;
    border_c = (pix_col < COL_W'(2)) || (pix_row == '0) || (pix_row == ROW_LAST);
  end

  // Mode and threshold are frame-stable, captured on sof only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 1'b0;
      thresh_r <= '1;
    end else if (valid_in && sof_in) begin
      mode_r   <= mode;
      thresh_r <= thresh;
    end
  end

  // Full-precision signed gradients from the post-shift window
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px[r][c] = GW'(win_nxt[r][c]);
    gx_pos = px[0][0] + (px[1][0] << 1) + px[2][0];
    gx_neg = px[0][2] + (px[1][2] << 1) + px[2][2];
    gy_pos = px[2][0] + (px[2][1] << 1) + px[2][2];
    gy_neg = px[0][0] + (px[0][1] << 1) + px[0][2];
    gx_c   = $signed(gx_pos - gx_neg);
    gy_c   = $signed(gy_pos - gy_neg);
  end

  // Stage 1: gradients plus valid/sof/border chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_r  <= '0;
      gy_r  <= '0;
      v1    <= 1'b0;
      sof1  <= 1'b0;
      bord1 <= 1'b0;
    end else begin
      gx_r  <= gx_c;
      gy_r  <= gy_c;
      v1    <= valid_in;
      sof1  <= valid_in & sof_in;
      bord1 <= border_c;
    end
  end

  // Magnitude, saturation, threshold and output selection
  always_comb begin
    gx_abs = gx_r[GW-1] ? (~$unsigned(gx_r) + GW'(1)) : $unsigned(gx_r);
    gy_abs = gy_r[GW-1] ? (~$unsigned(gy_r) + GW'(1)) : $unsigned(gy_r);
    mag_c  = gx_abs + gy_abs;
    sat_c  = (mag_c > SAT_MAX) ? PIX_ONES : mag_c[DATA_W-1:0];
    edge_c = !bord1 && (mag_c > thresh_r);
    if (bord1)       dout_c = '0;
    else if (mode_r) dout_c = edge_c ? PIX_ONES : '0;
    else             dout_c = sat_c;
  end

  // Stage 2: registered outputs, held while no pixel is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      dout      <= '0;
      edge_out  <= 1'b0;
    end else begin
      valid_out <= v1;
      if (v1) begin
        sof_out  <= sof1;
        dout     <= dout_c;
        edge_out <= edge_c;
      end
    end
  end

endmodule

// File: tb/tb_sobel_3x3_core.sv
// Self-checking bench for sobel_3x3_core (8-bit pixels, 8x4 frame).
module tb_sobel_3x3_core;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic          sof_in = 1'b0;
  logic [DW-1:0] din1 = '0, din2 = '0, din3 = '0;
  logic          mode = 1'b0;
  logic [DW+2:0] thresh = '0;
  logic          valid_out, sof_out, edge_out;
  logic [DW-1:0] dout;

  sobel_3x3_core #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
    .din1(din1), .din2(din2), .din3(din3), .mode(mode), .thresh(thresh),
    .valid_out(valid_out), .sof_out(sof_out), .dout(dout), .edge_out(edge_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout;
    logic       edge_o;
    logic       sof;
    int         cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Collect every output the DUT produces
  always @(negedge clk) if (rst_n && valid_out) obs_q.push_back('{dout, edge_out, sof_out, cyc});

  // Reference model state
  int h[3][3];
  int mc, mr, mmode, mthr;

  task automatic model_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) h[r][c] = 0;
    mc = 0; mr = 0; mmode = 0; mthr = 2047;
  endtask

  task automatic send(input int t, input int m, input int b, input bit sof);
    int pc, pr, gx, gy, mag, dv;
    bit bord, eg;
    @(negedge clk);
    din1 = 8'(t); din2 = 8'(m); din3 = 8'(b);
    valid_in = 1'b1; sof_in = sof;
    if (sof) begin pc = 0; pr = 0; mmode = int'(mode); mthr = int'(thresh); end
    else begin pc = mc; pr = mr; end
    if (sof) begin mc = 1; mr = 0; end
    else if (mc == IW - 1) begin mc = 0; mr = (mr == IH - 1) ? 0 : mr + 1; end
    else mc++;
    for (int r = 0; r < 3; r++) begin h[r][2] = h[r][1]; h[r][1] = h[r][0]; end
    h[0][0] = t; h[1][0] = m; h[2][0] = b;
    gx = (h[0][0] + 2*h[1][0] + h[2][0]) - (h[0][2] + 2*h[1][2] + h[2][2]);
    gy = (h[2][0] + 2*h[2][1] + h[2][2]) - (h[0][0] + 2*h[0][1] + h[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    bord = (pc < 2) || (pr == 0) || (pr == IH - 1);
    eg = !bord && (mag > mthr);
    if (bord) dv = 0;
    else if (mmode != 0) dv = eg ? 255 : 0;
    else dv = (mag > 255) ? 255 : mag;
    exp_q.push_back('{8'(dv), eg, sof, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); valid_in = 1'b0; sof_in = 1'b0; end
  endtask

  function automatic int pix(input int kind, input int c);
    case (kind)
      0: return 100;
      1: return (c >= 4) ? 255 : 0;
      2: return (c >= 4) ? 0 : 255;
      default: return 10 * c;
    endcase
  endfunction

  // Frame of identical rows; optional mid-frame config change at pixel sw_at
  task automatic send_frame(input int kind, input int gap, input int npix,
                            input int sw_at, input logic sw_mode, input int sw_thr);
    for (int i = 0; i < npix; i++) begin
      send(pix(kind, i % IW), pix(kind, i % IW), pix(kind, i % IW), i == 0);
      if (i == sw_at) begin mode = sw_mode; thresh = 11'(sw_thr); end
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(4);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    n_cmp++; if (sof_out !== 1'b0) begin n_err++; $display("FAIL reset sof_out: got %b want 0", sof_out); end
    n_cmp++; if (dout !== 8'd0) begin n_err++; $display("FAIL reset dout: got %0d want 0", dout); end
    n_cmp++; if (edge_out !== 1'b0) begin n_err++; $display("FAIL reset edge_out: got %b want 0", edge_out); end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reset idle outputs: got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_flat();
    rec_t e, o;
    int nsof = 0;
    mode = 1'b0; thresh = 11'd0;
    send_frame(0, 0, 32, -1, 1'b0, 0);
    idle(4);
    n_cmp++; if (obs_q.size() != 32) begin n_err++; $display("FAIL flat count: got %0d want 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
        n_err++; $display("FAIL flat pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                          o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
      end
      if (o.sof === 1'b1) nsof++;
    end
    n_cmp++; if (nsof != 1) begin n_err++; $display("FAIL flat sof count: got %0d want 1", nsof); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_steps();
    rec_t e, o;
    int n255;
    for (int k = 1; k <= 2; k++) begin
      n255 = 0;
      mode = 1'b0; thresh = 11'd500;
      send_frame(k, 0, 32, -1, 1'b0, 0);
      idle(4);
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL step%0d count: got %0d want %0d", k, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
          n_err++; $display("FAIL step%0d pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                            k, o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
        end
        if (o.dout == 8'd255 && o.edge_o === 1'b1) n255++;
      end
      n_cmp++; if (n255 != 4) begin n_err++; $display("FAIL step%0d edge count: got %0d want 4", k, n255); end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_ramp();
    rec_t e, o;
    int n80, ne;
    int thr_tab[2] = '{100, 79};
    int ne_want[2] = '{0, 12};
    for (int k = 0; k < 2; k++) begin
      n80 = 0; ne = 0;
      mode = 1'b0; thresh = 11'(thr_tab[k]);
      send_frame(3, 0, 32, -1, 1'b0, 0);
      idle(4);
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ramp count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
          n_err++; $display("FAIL ramp pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                            o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
        end
        if (o.dout == 8'd80) n80++;
        if (o.edge_o === 1'b1) ne++;
      end
      n_cmp++; if (n80 != 12) begin n_err++; $display("FAIL ramp dout80 count: got %0d want 12", n80); end
      n_cmp++; if (ne != ne_want[k]) begin n_err++; $display("FAIL ramp edge count thr=%0d: got %0d want %0d", thr_tab[k], ne, ne_want[k]); end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_mode_capture();
    rec_t e, o;
    int n255 = 0, n80 = 0, ne = 0;
    mode = 1'b1; thresh = 11'd500;
    send_frame(1, 0, 32, 12, 1'b0, 500);
    mode = 1'b1; thresh = 11'd50;
    send_frame(3, 0, 32, 12, 1'b0, 2000);
    send_frame(3, 0, 32, -1, 1'b0, 0);
    idle(4);
    n_cmp++; if (obs_q.size() != 96) begin n_err++; $display("FAIL mode count: got %0d want 96", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
        n_err++; $display("FAIL mode pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                          o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
      end
      if (o.dout == 8'd255) n255++;
      if (o.dout == 8'd80) n80++;
      if (o.edge_o === 1'b1) ne++;
    end
    n_cmp++; if (n255 != 16) begin n_err++; $display("FAIL mode binary count: got %0d want 16", n255); end
    n_cmp++; if (n80 != 12) begin n_err++; $display("FAIL mode magnitude count: got %0d want 12", n80); end
    n_cmp++; if (ne != 16) begin n_err++; $display("FAIL mode edge count: got %0d want 16", ne); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gapped();
    rec_t e, o;
    int n255 = 0;
    mode = 1'b0; thresh = 11'd500;
    send_frame(1, 2, 11, -1, 1'b0, 0);
    send_frame(1, 2, 32, -1, 1'b0, 0);
    idle(4);
    n_cmp++; if (obs_q.size() != 43) begin n_err++; $display("FAIL gap count: got %0d want 43", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
        n_err++; $display("FAIL gap pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                          o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
      end
      if (o.dout == 8'd255) n255++;
    end
    n_cmp++; if (n255 != 4) begin n_err++; $display("FAIL gap edge count: got %0d want 4", n255); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    rec_t e, o;
    for (int f = 0; f < 2; f++) begin
      mode = 1'(f); thresh = 11'($urandom_range(0, 1200));
      for (int i = 0; i < 32; i++)
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i == 0);
    end
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
        n_err++; $display("FAIL rand pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                          o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    mode = 1'b0; thresh = 11'd500;
    for (int i = 0; i < 6; i++) send(pix(1, i), pix(1, i), pix(1, i), i == 0);
    @(posedge clk);
    #2 rst_n = 1'b0; valid_in = 1'b0; sof_in = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL midreset valid_out: got %b want 0", valid_out); end
    n_cmp++; if (dout !== 8'd0 || edge_out !== 1'b0 || sof_out !== 1'b0) begin
      n_err++; $display("FAIL midreset outputs: got d=%0d e=%b s=%b want 0", dout, edge_out, sof_out);
    end
    exp_q.delete(); obs_q.delete();
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    send_frame(1, 0, 32, -1, 1'b0, 0);
    idle(4);
    n_cmp++; if (obs_q.size() != 32) begin n_err++; $display("FAIL midreset count: got %0d want 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.dout !== e.dout || o.edge_o !== e.edge_o || o.sof !== e.sof || o.cyc != e.cyc) begin
        n_err++; $display("FAIL midreset pixel: got d=%0d e=%b s=%b c=%0d want d=%0d e=%b s=%b c=%0d",
                          o.dout, o.edge_o, o.sof, o.cyc, e.dout, e.edge_o, e.sof, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_flat();
    test_steps();
    test_ramp();
    test_mode_capture();
    test_gapped();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
